branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Initiator side of the CPSR status-flag interface.
- Accepts decoded instructions from the decode stage with a valid/ready handshake.
- For flag-setting ALU ops: waits for ALU completion, then pulses cpsr_update.
- For conditional branches: drives ben/bvf, samples cpsr_out, and sequences the program counter (PC+4 or branch target) toward instruction fetch.

Parameters:
- PC_WIDTH, 32, program counter width.
- OFF_WIDTH, 16, branch word-offset width; sign-extended to PC_WIDTH.
- RESET_PC, 32'h0000_0000, PC value while reset_n is low.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- instr_valid  in  1  decode presents an instruction.
- instr_ready  out  1  block can accept; transfer occurs when instr_valid & instr_ready.
- is_setflags  in  1  instruction is an ALU op that updates flags.
- is_beq  in  1  branch if zero flag set.
- is_bneg  in  1  branch if sign flag set.
- is_bvf  in  1  branch if overflow flag set.
- br_offset  in  OFF_WIDTH  signed word offset.
- alu_done  in  1  ALU result and flags valid this cycle.
- cpsr_update  out  1  one-cycle pulse: CPSR latches ALU flags.
- cpsr_reset  out  1  clears CPSR flags.
- ben  out  1  zero/sign branch test request.
- bvf  out  1  overflow branch test request.
- cpsr_out  in  1  CPSR branch-condition result.
- pc  out  PC_WIDTH  current program counter.
- pc_we  out  1  one-cycle pulse when pc changes.
- taken  out  1  valid with pc_we: last branch was taken.
- illegal  out  1  one-cycle pulse: malformed branch encoding.

Behaviour:
- Reset (reset_n=0 at edge):
  - state=IDLE; pc=RESET_PC; instr_ready=0.
  - cpsr_update=ben=bvf=pc_we=taken=illegal=0.
  - cpsr_reset=1. It stays 1 for the first cycle after reset_n rises, then 0.
  - Reset overrides any in-flight operation with no partial PC update.
- States: IDLE, WAIT_ALU, FLAG_WR, BR_REQ, BR_EVAL.
- instr_ready=1 only in IDLE and not in the post-reset cpsr_reset cycle.
- IDLE, on accept:
  - Plain op (no flags asserted): pc<=pc+4, pc_we=1 next cycle, stay IDLE. Latency 1.
  - is_setflags: go to WAIT_ALU.
  - Exactly one of is_beq/is_bneg/is_bvf: latch the branch type and offset, go to BR_REQ.
  - More than one branch flag: pulse illegal, pc<=pc+4, taken=0, stay IDLE.
  - is_setflags together with any branch flag: also illegal, handled the same way.
- WAIT_ALU: hold until alu_done=1, then go to FLAG_WR. alu_done already high in the accept cycle is ignored; only alu_done in WAIT_ALU counts.
- FLAG_WR: cpsr_update=1 for exactly this cycle; pc<=pc+4 with pc_we; go to IDLE.
- BR_REQ:
  - ben=1 for beq and bneg; bvf=1 for bvf. Held through BR_EVAL.
  - This cycle lets cpsr_out settle.
- BR_EVAL:
  - Sample cpsr_out.
  - If 1: pc<=pc+4+(sext(br_offset)<<2), taken=1.
  - If 0: pc<=pc+4, taken=0.
  - pc_we=1 in the following cycle; ben/bvf drop to 0; go to IDLE.
- Branch latency: accept edge to pc_we = 3 cycles.
- Arithmetic: all PC sums modulo 2^PC_WIDTH; wrap-around is silent. Negative offsets reach backward targets.
- cpsr_update and ben/bvf are never asserted in the same cycle.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - state enum (IDLE, WAIT_ALU, FLAG_WR, BR_REQ, BR_EVAL).
  - branch-type encoding (BR_EQ, BR_NEG, BR_VF).
  - PC_INC = 4.
- One sub-module, pc_target_calc: combinational sign-extend, shift, and add producing pc+4 and the branch target.

Test Plan:
- Reset release:
  - Hold reset_n=0 for 3 cycles, then release.
  - Expect pc=0, cpsr_reset=1 through the first post-release cycle, then instr_ready=1.
- Plain ops:
  - 3 back-to-back plain instructions from pc=0.
  - Expect pc=4, 8, 12, each with a single pc_we pulse.
- Flag write with delayed ALU:
  - is_setflags with alu_done arriving 2 cycles after accept.
  - Expect cpsr_update high exactly 1 cycle, the cycle after alu_done; instr_ready=0 throughout; pc advances by 4.
- Branch taken, backward:
  - is_beq, br_offset=16'hFFFE, pc=0x100, cpsr_out=1 during BR_EVAL.
  - Expect ben=1 for 2 cycles, pc=0x0FC, taken=1.
- Branch not taken:
  - is_bvf, br_offset=5, pc=0x20, cpsr_out=0.
  - Expect bvf=1 for 2 cycles, pc=0x24, taken=0.
- Illegal encoding and reset mid-operation:
  - is_beq & is_bvf asserted together: expect an illegal pulse and pc+4.
  - Separately, assert reset_n=0 while in BR_REQ: expect pc=RESET_PC, ben=0, no pc_we.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : cpu_ctrl_pkg
// Brief   : Shared types and constants for the branch/flag control path.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_ALU = 3'd1,
    FLAG_WR  = 3'd2,
    BR_REQ   = 3'd3,
    BR_EVAL  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    BR_EQ  = 2'd0,
    BR_NEG = 2'd1,
    BR_VF  = 2'd2
  } br_type_t;

  localparam int PC_INC = 4;

endpackage

`default_nettype wire

// File: rtl/branch_resolve_ctrl_if.sv
//------------------------------------------------------------------------------
// Module  : branch_resolve_ctrl_if
// Brief   : Decode handshake, ALU/CPSR side-band and fetch PC bundle.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface branch_resolve_ctrl_if #(
  parameter int PC_WIDTH  = 32,
  parameter int OFF_WIDTH = 16
);

  logic                 instr_valid;
  logic                 instr_ready;
  logic                 is_setflags;
  logic                 is_beq;
  logic                 is_bneg;
  logic                 is_bvf;
  logic [OFF_WIDTH-1:0] br_offset;
  logic                 alu_done;
  logic                 cpsr_update;
  logic                 cpsr_reset;
  logic                 ben;
  logic                 bvf;
  logic                 cpsr_out;
  logic [PC_WIDTH-1:0]  pc;
  logic                 pc_we;
  logic                 taken;
  logic                 illegal;

  // Controller side
  modport master (
    input  instr_valid, is_setflags, is_beq, is_bneg, is_bvf, br_offset,
    input  alu_done, cpsr_out,
    output instr_ready, cpsr_update, cpsr_reset, ben, bvf,
    output pc, pc_we, taken, illegal
  );

  // Decode / ALU / CPSR / fetch side
  modport slave (
    output instr_valid, is_setflags, is_beq, is_bneg, is_bvf, br_offset,
    output alu_done, cpsr_out,
    input  instr_ready, cpsr_update, cpsr_reset, ben, bvf,
    input  pc, pc_we, taken, illegal
  );

endinterface

`default_nettype wire

// File: rtl/pc_target_calc.sv
//------------------------------------------------------------------------------
// Module  : pc_target_calc
// Brief   : Sequential PC and word-offset branch target (modulo 2^PC_WIDTH).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_target_calc
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int OFF_WIDTH = 16
) (
  input  wire logic [PC_WIDTH-1:0]  i_pc,
  input  wire logic [OFF_WIDTH-1:0] i_offset,
  output logic      [PC_WIDTH-1:0]  o_pc_plus4,
  output logic      [PC_WIDTH-1:0]  o_br_target
);

  logic [PC_WIDTH-1:0] w_off_ext;

  assign w_off_ext   = PC_WIDTH'($signed(i_offset));
  assign o_pc_plus4  = i_pc + PC_WIDTH'(PC_INC);
  // Offset counts words; target is relative to the sequential PC
  assign o_br_target = o_pc_plus4 + (w_off_ext << 2);

endmodule

`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
//------------------------------------------------------------------------------
// Module  : branch_resolve_ctrl
// Brief   : Sequences flag-setting ops and conditional branches, owns the PC.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_resolve_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int                  PC_WIDTH  = 32,
  parameter int                  OFF_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input wire logic              clk,
  input wire logic              reset_n,
  branch_resolve_ctrl_if.master bus
);

  state_t               r_state;
  state_t               w_state_nxt;
  br_type_t             r_br_type;
  br_type_t             w_br_type;
  logic [OFF_WIDTH-1:0] r_offset;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [PC_WIDTH-1:0]  w_pc_nxt;
  logic [PC_WIDTH-1:0]  w_pc_plus4;
  logic [PC_WIDTH-1:0]  w_br_target;
  logic                 r_pc_we;
  logic                 w_pc_we_nxt;
  logic                 r_taken;
  logic                 w_taken_nxt;
  logic                 r_illegal;
  logic                 w_illegal_nxt;
  logic                 r_rst_hold;
  logic                 r_cpsr_reset;
  logic                 w_instr_ready;
  logic                 w_accept;
  logic [1:0]           w_br_cnt;
  logic                 w_is_illegal;
  logic                 w_br_active;

  pc_target_calc #(
    .PC_WIDTH  (PC_WIDTH),
    .OFF_WIDTH (OFF_WIDTH)
  ) u_pc_target_calc (
    .i_pc        (r_pc),
    .i_offset    (r_offset),
    .o_pc_plus4  (w_pc_plus4),
    .o_br_target (w_br_target)
  );

  assign w_instr_ready = (r_state == IDLE) && !r_cpsr_reset;
  assign w_accept      = bus.instr_valid && w_instr_ready;
  assign w_br_cnt      = {1'b0, bus.is_beq} + {1'b0, bus.is_bneg} + {1'b0, bus.is_bvf};
  assign w_is_illegal  = (w_br_cnt > 2'd1) || (bus.is_setflags && (w_br_cnt != 2'd0));
  assign w_br_type     = bus.is_bvf ? BR_VF : (bus.is_bneg ? BR_NEG : BR_EQ);

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = w_pc_plus4;
    w_pc_we_nxt   = 1'b0;
    w_taken_nxt   = 1'b0;
    w_illegal_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_illegal) begin
            w_illegal_nxt = 1'b1;
            w_pc_we_nxt   = 1'b1;
          end else if (bus.is_setflags) begin
            w_state_nxt = WAIT_ALU;
          end else if (w_br_cnt == 2'd1) begin
            w_state_nxt = BR_REQ;
          end else begin
            w_pc_we_nxt = 1'b1;
          end
        end
      end
      WAIT_ALU: begin
        if (bus.alu_done) begin
          w_state_nxt = FLAG_WR;
        end
      end
      FLAG_WR: begin
        w_pc_we_nxt = 1'b1;
        w_state_nxt = IDLE;
      end
      BR_REQ: begin
        w_state_nxt = BR_EVAL;
      end
      BR_EVAL: begin
        w_pc_we_nxt = 1'b1;
        w_taken_nxt = bus.cpsr_out;
        w_pc_nxt    = bus.cpsr_out ? w_br_target : w_pc_plus4;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // cpsr_reset trails reset release by one full cycle via r_rst_hold
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_pc_we      <= 1'b0;
      r_taken      <= 1'b0;
      r_illegal    <= 1'b0;
      r_rst_hold   <= 1'b1;
      r_cpsr_reset <= 1'b1;
      r_br_type    <= BR_EQ;
      r_offset     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc_we      <= w_pc_we_nxt;
      r_taken      <= w_taken_nxt;
      r_illegal    <= w_illegal_nxt;
      r_rst_hold   <= 1'b0;
      r_cpsr_reset <= r_rst_hold;
      if (w_pc_we_nxt) begin
        r_pc <= w_pc_nxt;
      end
      if (w_accept) begin
        r_br_type <= w_br_type;
        r_offset  <= bus.br_offset;
      end
    end
  end

  assign w_br_active = (r_state == BR_REQ) || (r_state == BR_EVAL);

  assign bus.instr_ready = w_instr_ready;
  assign bus.cpsr_update = (r_state == FLAG_WR);
  assign bus.cpsr_reset  = r_cpsr_reset;
  assign bus.ben         = w_br_active && (r_br_type != BR_VF);
  assign bus.bvf         = w_br_active && (r_br_type == BR_VF);
  assign bus.pc          = r_pc;
  assign bus.pc_we       = r_pc_we;
  assign bus.taken       = r_taken;
  assign bus.illegal     = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_branch_resolve_ctrl
// Brief   : Self-checking bench; PC-update scoreboard plus per-scenario checks.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_branch_resolve_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic        illegal;
  } upd_t;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  logic [31:0] exp_pc;
  upd_t exp_q[$];
  upd_t obs_q[$];

  branch_resolve_ctrl_if #(.PC_WIDTH(32), .OFF_WIDTH(16)) bus ();

  branch_resolve_ctrl #(
    .PC_WIDTH  (32),
    .OFF_WIDTH (16),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every PC update seen by fetch is captured for the scoreboard
  always @(negedge clk) begin
    if (bus.pc_we) obs_q.push_back('{pc: bus.pc, taken: bus.taken, illegal: bus.illegal});
  end

  task automatic clear_inputs();
    bus.instr_valid = 1'b0;
    bus.is_setflags = 1'b0;
    bus.is_beq      = 1'b0;
    bus.is_bneg     = 1'b0;
    bus.is_bvf      = 1'b0;
    bus.br_offset   = '0;
    bus.alu_done    = 1'b0;
    bus.cpsr_out    = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    obs_q.delete();
    exp_pc = 32'h0;
  endtask

  // Presents one instruction and holds it until accepted; returns at accept edge + 1
  task automatic send(input logic sf, input logic eq, input logic ng, input logic vf,
                      input logic [15:0] off);
    bit done;
    done = 1'b0;
    bus.is_setflags = sf;
    bus.is_beq      = eq;
    bus.is_bneg     = ng;
    bus.is_bvf      = vf;
    bus.br_offset   = off;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.instr_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: instr_ready never seen");
    end
    bus.instr_valid = 1'b0;
    bus.is_setflags = 1'b0;
    bus.is_beq      = 1'b0;
    bus.is_bneg     = 1'b0;
    bus.is_bvf      = 1'b0;
  endtask

  task automatic wait_obs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (obs_q.size() >= exp_q.size()) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.pc, bus.cpsr_reset, bus.instr_ready, bus.pc_we, bus.ben, bus.bvf,
         bus.cpsr_update, bus.taken, bus.illegal} !== {32'h0, 1'b1, 1'b0, 6'b0}) begin
      errors++;
      $display("FAIL reset_first_cycle: pc=%h cpsr_reset=%b ready=%b pc_we=%b ben=%b bvf=%b upd=%b expected pc=0 cpsr_reset=1 others 0",
               bus.pc, bus.cpsr_reset, bus.instr_ready, bus.pc_we, bus.ben, bus.bvf, bus.cpsr_update);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.cpsr_reset, bus.instr_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_release: cpsr_reset=%b ready=%b expected cpsr_reset=0 ready=1",
               bus.cpsr_reset, bus.instr_ready);
    end
    @(posedge clk);
    #1;
    exp_pc = 32'h0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_plain_ops(input int n);
    bit ok;
    upd_t e, o;
    for (int i = 0; i < n; i++) begin
      exp_pc = exp_pc + 32'd4;
      exp_q.push_back('{pc: exp_pc, taken: 1'b0, illegal: 1'b0});
      send(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    end
    wait_obs(ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL plain_pc_we_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL plain_update: got pc=%h taken=%b ill=%b expected pc=%h taken=%b ill=%b",
                 o.pc, o.taken, o.illegal, e.pc, e.taken, e.illegal);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_flag_write();
    bit ok;
    int upd_cnt;
    logic any_ready, any_br;
    upd_t e, o;
    upd_cnt   = 0;
    any_ready = 1'b0;
    any_br    = 1'b0;
    exp_pc = exp_pc + 32'd4;
    exp_q.push_back('{pc: exp_pc, taken: 1'b0, illegal: 1'b0});
    bus.alu_done = 1'b1;  // high during the accept cycle must be ignored
    send(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      bus.alu_done = (i == 1);
      @(negedge clk);
      if (bus.cpsr_update) upd_cnt++;
      if (bus.cpsr_update && (bus.ben || bus.bvf)) any_br = 1'b1;
      if (i < 3 && bus.instr_ready) any_ready = 1'b1;
      checks++;
      if (bus.cpsr_update !== (i == 2)) begin
        errors++;
        $display("FAIL flag_update_cycle%0d: cpsr_update=%b expected %b", i, bus.cpsr_update, (i == 2));
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (upd_cnt != 1 || any_ready || any_br) begin
      errors++;
      $display("FAIL flag_pulse: count=%0d ready_seen=%b with_branch=%b expected count=1 ready_seen=0 with_branch=0",
               upd_cnt, any_ready, any_br);
    end
    wait_obs(ok);
    checks++;
    if (!ok || obs_q.size() != 1) begin
      errors++;
      $display("FAIL flag_pc_we_count: got %0d expected 1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL flag_update: got pc=%h expected pc=%h", o.pc, e.pc);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // sched_cpsr gives cpsr_out for the BR_REQ and BR_EVAL cycles respectively
  task automatic test_branch(input string name, input logic eq, input logic ng, input logic vf,
                             input logic [15:0] off, input logic [1:0] sched_cpsr,
                             input logic [31:0] exp_target, input logic exp_taken);
    bit ok;
    int ben_cnt, bvf_cnt;
    upd_t e, o;
    ben_cnt = 0;
    bvf_cnt = 0;
    exp_pc = exp_target;
    exp_q.push_back('{pc: exp_target, taken: exp_taken, illegal: 1'b0});
    send(1'b0, eq, ng, vf, off);
    for (int i = 0; i < 4; i++) begin
      bus.cpsr_out = (i == 0) ? sched_cpsr[1] : ((i == 1) ? sched_cpsr[0] : 1'b0);
      @(negedge clk);
      if (bus.ben) ben_cnt++;
      if (bus.bvf) bvf_cnt++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (ben_cnt != (vf ? 0 : 2) || bvf_cnt != (vf ? 2 : 0)) begin
      errors++;
      $display("FAIL %s_req: ben_cycles=%0d bvf_cycles=%0d expected ben=%0d bvf=%0d",
               name, ben_cnt, bvf_cnt, vf ? 0 : 2, vf ? 2 : 0);
    end
    wait_obs(ok);
    checks++;
    if (!ok || obs_q.size() != 1) begin
      errors++;
      $display("FAIL %s_pc_we_count: got %0d expected 1", name, obs_q.size());
    end
    if (obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s_update: got pc=%h taken=%b ill=%b expected pc=%h taken=%b ill=%b",
                 name, o.pc, o.taken, o.illegal, e.pc, e.taken, e.illegal);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_illegal(input logic sf, input logic eq, input logic ng, input logic vf);
    bit ok;
    upd_t e, o;
    exp_pc = exp_pc + 32'd4;
    exp_q.push_back('{pc: exp_pc, taken: 1'b0, illegal: 1'b1});
    send(sf, eq, ng, vf, 16'h0007);
    @(negedge clk);
    checks++;
    if ({bus.instr_ready, bus.ben, bus.bvf, bus.cpsr_update} !== 4'b1000) begin
      errors++;
      $display("FAIL illegal_state: ready=%b ben=%b bvf=%b upd=%b expected ready=1 others 0",
               bus.instr_ready, bus.ben, bus.bvf, bus.cpsr_update);
    end
    wait_obs(ok);
    checks++;
    if (!ok || obs_q.size() != 1) begin
      errors++;
      $display("FAIL illegal_pc_we_count: got %0d expected 1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL illegal_update: got pc=%h taken=%b ill=%b expected pc=%h taken=%b ill=%b",
                 o.pc, o.taken, o.illegal, e.pc, e.taken, e.illegal);
      end
    end
    exp_q.delete();
    obs_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op();
    send(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010);
    @(negedge clk);
    checks++;
    if (bus.ben !== 1'b1) begin
      errors++;
      $display("FAIL midreset_in_br_req: ben=%b expected 1", bus.ben);
    end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.pc, bus.ben, bus.bvf, bus.pc_we, bus.cpsr_reset} !== {32'h0, 4'b0001}) begin
      errors++;
      $display("FAIL midreset_state: pc=%h ben=%b bvf=%b pc_we=%b cpsr_reset=%b expected pc=0 ben=0 bvf=0 pc_we=0 cpsr_reset=1",
               bus.pc, bus.ben, bus.bvf, bus.pc_we, bus.cpsr_reset);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || bus.pc !== 32'h0) begin
      errors++;
      $display("FAIL midreset_no_update: pc_we_seen=%0d pc=%h expected 0 and pc=0", obs_q.size(), bus.pc);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    exp_pc  = 32'h0;
    reset_n = 1'b0;
    clear_inputs();
    test_reset();
    test_plain_ops(3);
    test_flag_write();
    test_illegal(1'b0, 1'b1, 1'b0, 1'b1);
    test_illegal(1'b1, 1'b0, 1'b1, 1'b0);
    test_plain_ops((32'h100 - exp_pc) / 4);
    test_branch("beq_taken_back", 1'b1, 1'b0, 1'b0, 16'hFFFE, 2'b01, 32'h0000_00FC, 1'b1);
    do_reset();
    test_plain_ops(8);
    test_branch("bvf_not_taken", 1'b0, 1'b0, 1'b1, 16'h0005, 2'b10, 32'h0000_0024, 1'b0);
    test_branch("bneg_taken_fwd", 1'b0, 1'b1, 1'b0, 16'h0003, 2'b01, 32'h0000_0034, 1'b1);
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
